// File: rtl/lw_mbox_pkg.sv
// Shared definitions for the lightweight-bridge mailbox responder.
// Contents:
//   - byte offsets of the register bank and the mailbox window
//   - FSM state type and the address-decode selector type
//   - lane_mask(): expands a 4-bit byte enable into a 32-bit bit mask
package lw_mbox_pkg;

    localparam logic [17:0] OFF_ID   = 18'h000;
    localparam logic [17:0] OFF_CTRL = 18'h004;
    localparam logic [17:0] OFF_PEND = 18'h008;
    localparam logic [17:0] OFF_DB   = 18'h00C;
    localparam logic [17:0] OFF_MBOX = 18'h400;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ID,
        SEL_CTRL,
        SEL_PEND,
        SEL_DB,
        SEL_MBOX
    } sel_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/lw_mbox_ram.sv
// Simple dual-port synchronous RAM backing the mailbox window.
// One byte-enabled write port and one read port; the read returns data one
// cycle after the address and yields the old contents on a same-edge
// read/write collision.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write word address
//   be     in   per-byte write enables
//   wdata  in   write data
//   raddr  in   read word address
//   rdata  out  registered read data
module lw_mbox_ram #(
    parameter  int unsigned WORDS = 64,
    localparam int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the array has no reset; the owner clears it by walking every word after reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lw_bridge_mailbox_responder.sv
// Avalon-MM slave terminating the HPS lightweight bridge in the fabric.
// Provides an ID/CTRL/PENDING/DOORBELL register bank, a zero-initialised
// mailbox RAM and a level interrupt raised by enabled pending doorbells.
// Reads return after exactly two cycles, fully pipelined; writes take one.
// Ports:
//   clk100_clk          in   clock
//   reset_clk100_reset  in   synchronous active-high reset
//   avs_address         in   byte address, [1:0] ignored
//   avs_read/avs_write  in   command strobes
//   avs_writedata       in   write data
//   avs_byteenable      in   write byte lanes
//   avs_burstcount      in   ignored
//   avs_debugaccess     in   ignored
//   avs_waitrequest     out  stall during reset and mailbox clear
//   avs_readdata        out  read data
//   avs_readdatavalid   out  read response strobe
//   db_event_i          in   fabric doorbell pulses
//   irq_o               out  level interrupt to the HPS
module lw_bridge_mailbox_responder
    import lw_mbox_pkg::*;
#(
    parameter int unsigned MBOX_WORDS = 64,
    parameter int unsigned NUM_DB     = 8,
    parameter logic [31:0] ID_VALUE   = 32'h4D42_0100
) (
    input  logic              clk100_clk,
    input  logic              reset_clk100_reset,
    input  logic [17:0]       avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_burstcount,
    input  logic              avs_debugaccess,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [NUM_DB-1:0] db_event_i,
    output logic              irq_o
);

    localparam int unsigned AW = $clog2(MBOX_WORDS);

    state_t            state_q, state_d;
    logic [AW-1:0]     init_cnt_q;
    logic              rd_go, wr_go;
    sel_t              sel;
    logic [31:0]       wmask, wdata_m, reg_rdata;
    logic [NUM_DB-1:0] ctrl_q, pend_q, pend_d, w1c, db_wr;
    logic              s1_valid, s1_mbox;
    logic [31:0]       s1_data;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata, ram_q;
    logic              unused_inputs;

    assign unused_inputs = &{1'b0, avs_burstcount, avs_debugaccess, avs_address[1:0]};

    // ---------------- init FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk100_clk) begin
        if (reset_clk100_reset) state_q <= ST_INIT;
        else                    state_q <= state_d;
    end

    // Word counter runs only while clearing; parks at 0 so a later reset restarts cleanly.
    always_ff @(posedge clk100_clk) begin
        if (reset_clk100_reset || state_q != ST_INIT) init_cnt_q <= '0;
        else                                          init_cnt_q <= init_cnt_q + 1'b1;
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves an output unassigned, which would infer a latch.
        state_d         = state_q;
        avs_waitrequest = 1'b1;
        case (state_q)
            ST_INIT: if (init_cnt_q == AW'(MBOX_WORDS - 1)) state_d = ST_IDLE;
            ST_IDLE: avs_waitrequest = reset_clk100_reset;
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- decode ----------------
    // A simultaneous read and write is a protocol error: the write goes ahead, the read is dropped.
    assign wr_go = ~avs_waitrequest & avs_write;
    assign rd_go = ~avs_waitrequest & avs_read & ~avs_write;

    always_comb begin
        sel = SEL_NONE;
        if      (avs_address[17:2] == OFF_ID[17:2])   sel = SEL_ID;
        else if (avs_address[17:2] == OFF_CTRL[17:2]) sel = SEL_CTRL;
        else if (avs_address[17:2] == OFF_PEND[17:2]) sel = SEL_PEND;
        else if (avs_address[17:2] == OFF_DB[17:2])   sel = SEL_DB;
        else if (avs_address[17:10] == OFF_MBOX[17:10] &&
                 {1'b0, avs_address[9:2]} < 9'(MBOX_WORDS)) sel = SEL_MBOX;
    end

    assign wmask   = lane_mask(avs_byteenable);
    assign wdata_m = avs_writedata & wmask;

    // ---------------- pending / ctrl / irq ----------------
    assign w1c    = (wr_go && sel == SEL_PEND) ? wdata_m[NUM_DB-1:0] : '0;
    assign db_wr  = (wr_go && sel == SEL_DB)   ? wdata_m[NUM_DB-1:0] : '0;
    // Sets are OR-ed in after the clear, so a doorbell beats a same-cycle clear.
    assign pend_d = (pend_q & ~w1c) | db_event_i | db_wr;

    always_ff @(posedge clk100_clk) begin
        if (reset_clk100_reset) begin
            ctrl_q <= '0;
            pend_q <= '0;
            irq_o  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (wr_go && sel == SEL_CTRL) begin
                ctrl_q <= (ctrl_q & ~wmask[NUM_DB-1:0]) | wdata_m[NUM_DB-1:0];
            end
            irq_o <= |(pend_q & ctrl_q);
        end
    end

    // ---------------- mailbox RAM ----------------
    // A write commits at the end of its accept cycle, so a read accepted in the next
    // cycle samples the array after the update; the only same-edge collision would be a
    // simultaneous read+write, whose read is dropped. The read path therefore never needs
    // to forward write data around the array.
    assign ram_we    = (state_q == ST_INIT) | (wr_go && sel == SEL_MBOX);
    assign ram_waddr = (state_q == ST_INIT) ? init_cnt_q : avs_address[AW+1:2];
    assign ram_be    = (state_q == ST_INIT) ? 4'hF : avs_byteenable;
    assign ram_wdata = (state_q == ST_INIT) ? 32'h0 : avs_writedata;

    lw_mbox_ram #(.WORDS(MBOX_WORDS)) u_ram (
        .clk   (clk100_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .raddr (avs_address[AW+1:2]),
        .rdata (ram_q)
    );

    // ---------------- read response pipeline ----------------
    always_comb begin
        reg_rdata = '0;
        case (sel)
            SEL_ID:   reg_rdata = ID_VALUE;
            SEL_CTRL: reg_rdata[NUM_DB-1:0] = ctrl_q;
            SEL_PEND: reg_rdata[NUM_DB-1:0] = pend_q;
            default:  reg_rdata = '0;
        endcase
    end

    // Stage 1 holds register data captured at accept time; RAM data arrives alongside it.
    always_ff @(posedge clk100_clk) begin
        if (reset_clk100_reset) begin
            s1_valid          <= 1'b0;
            s1_mbox           <= 1'b0;
            s1_data           <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            s1_valid          <= rd_go;
            s1_mbox           <= rd_go && sel == SEL_MBOX;
            s1_data           <= reg_rdata;
            avs_readdatavalid <= s1_valid;
            if (s1_valid) avs_readdata <= s1_mbox ? ram_q : s1_data;
        end
    end

endmodule

// File: tb/tb_lw_bridge_mailbox_responder.sv
// Self-checking bench for lw_bridge_mailbox_responder: directed sequences,
// a table of vectors with fixed expectations and a randomized phase checked
// against a behavioural model of the register map and mailbox.
module tb_lw_bridge_mailbox_responder;

    localparam logic [31:0] ID = 32'h4D42_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] address = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        burst = 1'b1, dbg = 1'b0;
    logic        waitreq, rvalid, irq;
    logic [31:0] rdata;
    logic [7:0]  db = '0;

    lw_bridge_mailbox_responder dut (
        .clk100_clk         (clk),
        .reset_clk100_reset (rst),
        .avs_address        (address),
        .avs_read           (rd),
        .avs_write          (wr),
        .avs_writedata      (wdata),
        .avs_byteenable     (be),
        .avs_burstcount     (burst),
        .avs_debugaccess    (dbg),
        .avs_waitrequest    (waitreq),
        .avs_readdata       (rdata),
        .avs_readdatavalid  (rvalid),
        .db_event_i         (db),
        .irq_o              (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mbox [64];
    logic [7:0]  m_ctrl, m_pend;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_mbox[i] = '0;
        m_ctrl = '0;
        m_pend = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [17:0] a);
        int w = int'(a) / 4;
        if (w == 0) return ID;
        if (w == 1) return {24'h0, m_ctrl};
        if (w == 2) return {24'h0, m_pend};
        if (w >= 256 && w < 256 + 64) return m_mbox[w - 256];
        return 32'h0;
    endfunction

    function automatic logic model_irq_next();
        return (m_pend & m_ctrl) != 8'h0;
    endfunction

    function automatic void model_apply(input bit w_en, input logic [17:0] a, input logic [31:0] d,
                                        input logic [3:0] b, input logic [7:0] ev);
        logic [31:0] m;
        logic [7:0]  clr = '0;
        logic [7:0]  set = ev;
        int          w = int'(a) / 4;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
        if (w_en) begin
            if (w == 1) m_ctrl = (m_ctrl & ~m[7:0]) | (d[7:0] & m[7:0]);
            if (w == 2) clr = d[7:0] & m[7:0];
            if (w == 3) set = set | (d[7:0] & m[7:0]);
            if (w >= 256 && w < 256 + 64) m_mbox[w - 256] = (m_mbox[w - 256] & ~m) | (d & m);
        end
        m_pend = (m_pend & ~clr) | set;
    endfunction

    // ---------------- response scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 32'(rvalid), 32'd1);
            check("rsp_data", rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else if (rvalid === 1'b1) begin
            check("rsp_unexpected", 32'(rvalid), 32'd0);
        end
    end

    // One bus cycle, driven at a falling edge; checks irq after the following rising edge.
    task automatic drive_cycle(input bit r, input bit w, input logic [17:0] a, input logic [31:0] d,
                               input logic [3:0] b, input logic [7:0] ev, input bit exp_rsp,
                               input logic [31:0] exp_rd, input logic exp_irq);
        rd = r; wr = w; address = a; wdata = d; be = b; db = ev;
        if (exp_rsp) exp_q.push_back('{cyc + 2, exp_rd});
        model_apply(w, a, d, b, ev);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; db = '0;
        check("irq", 32'(irq), 32'(exp_irq));
    endtask

    task automatic rd_cycle(input logic [17:0] a, input logic [31:0] e, input logic ei);
        drive_cycle(1'b1, 1'b0, a, 32'h0, 4'h0, 8'h0, 1'b1, e, ei);
    endtask

    task automatic wr_cycle(input logic [17:0] a, input logic [31:0] d, input logic [3:0] b,
                            input logic [7:0] ev, input logic ei);
        drive_cycle(1'b0, 1'b1, a, d, b, ev, 1'b0, 32'h0, ei);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 32'(waitreq), 32'd1);
        check("rst_readdatavalid", 32'(rvalid), 32'd0);
        check("rst_readdata", rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        model_reset();
        rst = 1'b0;
        begin
            int n = 0;
            while (waitreq === 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("init_cycles", n, 32'd64);
        end
    endtask

    task automatic read_all_mbox_zero();
        for (int i = 0; i < 64; i++) rd_cycle(18'h400 + 18'(4 * i), 32'h0, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r;
        bit          w;
        logic [17:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit w, input logic [17:0] a, input logic [31:0] d,
                                input logic [3:0] b, input logic [31:0] e);
        tbl.push_back('{r, w, a, d, b, e, 1'b0});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        add(0, 1, 18'h004, 32'hFFFF_FFFF, 4'b0001, 32'h0);          // CTRL = 0xFF via lane 0
        add(1, 0, 18'h004, 32'h0,         4'h0,    32'h0000_00FF);
        add(0, 1, 18'h408, 32'h1122_3344, 4'hF,    32'h0);
        add(1, 0, 18'h408, 32'h0,         4'h0,    32'h1122_3344);
        add(0, 1, 18'h408, 32'hAABB_CCDD, 4'b1000, 32'h0);
        add(1, 0, 18'h408, 32'h0,         4'h0,    32'hAA22_3344);
        add(1, 1, 18'h40C, 32'h0000_0005, 4'hF,    32'h0);          // read+write: write only
        add(1, 0, 18'h40C, 32'h0,         4'h0,    32'h0000_0005);
        add(1, 0, 18'h4FC, 32'h0,         4'h0,    32'h0);          // last mailbox word
        add(0, 1, 18'h500, 32'hDEAD_BEEF, 4'hF,    32'h0);          // beyond mailbox: dropped
        add(1, 0, 18'h500, 32'h0,         4'h0,    32'h0);
        add(1, 0, 18'h400, 32'h0,         4'h0,    32'h0);          // must not alias 0x500
        add(0, 1, 18'h000, 32'hFFFF_FFFF, 4'hF,    32'h0);          // ID is read-only
        add(1, 0, 18'h000, 32'h0,         4'h0,    ID);
        add(1, 0, 18'h3FC, 32'h0,         4'h0,    32'h0);          // unmapped gap
        add(1, 0, 18'h010, 32'h0,         4'h0,    32'h0);
        add(0, 1, 18'h004, 32'h0,         4'hF,    32'h0);
        add(1, 0, 18'h004, 32'h0,         4'h0,    32'h0);

        // 1. reset release and zeroed mailbox
        @(negedge clk);
        do_reset();
        read_all_mbox_zero();

        // 2. ID read latency and back-to-back register reads
        rd_cycle(18'h000, ID, 1'b0);
        repeat (4) @(negedge clk);
        rd_cycle(18'h000, ID, 1'b0);
        rd_cycle(18'h004, 32'h0, 1'b0);
        rd_cycle(18'h008, 32'h0, 1'b0);
        repeat (4) @(negedge clk);

        // 3. byte-enabled write then immediate read-back
        wr_cycle(18'h404, 32'hA5A5_1234, 4'b0101, 8'h0, 1'b0);
        rd_cycle(18'h404, 32'h00A5_0034, 1'b0);
        repeat (4) @(negedge clk);

        // table-driven vectors
        foreach (tbl[i]) begin
            drive_cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, 8'h0,
                        tbl[i].r && !tbl[i].w, tbl[i].exp_rd, tbl[i].exp_irq);
        end
        repeat (4) @(negedge clk);

        // 4. doorbell event raises irq; set wins over same-cycle clear
        wr_cycle(18'h004, 32'h0000_0001, 4'hF, 8'h00, 1'b0);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h01, 1'b0, 32'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h00, 1'b0, 32'h0, 1'b1);
        wr_cycle(18'h008, 32'h0000_0001, 4'b0001, 8'h01, 1'b1);
        rd_cycle(18'h008, 32'h0000_0001, 1'b1);
        wr_cycle(18'h008, 32'h0000_0001, 4'b0001, 8'h00, 1'b1);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h00, 1'b0, 32'h0, 1'b0);

        // 5. software doorbell with irq masked, then enabled, then lane-gated clear
        wr_cycle(18'h004, 32'h0, 4'hF, 8'h00, 1'b0);
        wr_cycle(18'h00C, 32'h0000_0080, 4'b0001, 8'h00, 1'b0);
        rd_cycle(18'h008, 32'h0000_0080, 1'b0);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h00, 1'b0, 32'h0, 1'b0);
        wr_cycle(18'h004, 32'h0000_0080, 4'hF, 8'h00, 1'b0);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h00, 1'b0, 32'h0, 1'b1);
        rd_cycle(18'h00C, 32'h0, 1'b1);
        wr_cycle(18'h008, 32'hFFFF_FFFF, 4'b1110, 8'h00, 1'b1);
        rd_cycle(18'h008, 32'h0000_0080, 1'b1);
        wr_cycle(18'h008, 32'hFFFF_FFFF, 4'b0001, 8'h00, 1'b1);
        drive_cycle(1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 8'h00, 1'b0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [17:0] a;
            logic [7:0]  ev;
            int          op = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       a = 18'(4 * $urandom_range(0, 4));
                1, 2:    a = 18'h400 + 18'(4 * $urandom_range(0, 63));
                default: a = ($urandom_range(0, 1) == 1) ? 18'h500 + 18'(4 * $urandom_range(0, 7))
                                                         : 18'h200 + 18'(4 * $urandom_range(0, 7));
            endcase
            a[1:0] = 2'($urandom);
            ev  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
            dbg = 1'($urandom);
            drive_cycle(op < 4 || op == 9, op >= 4 && op != 8, a, $urandom, 4'($urandom), ev,
                        op < 4, model_read(a), model_irq_next());
        end
        repeat (4) @(negedge clk);

        // 6. reset with reads in flight; mailbox re-zeroed
        rd_cycle(18'h000, ID, model_irq_next());
        drive_cycle(1'b1, 1'b0, 18'h404, 32'h0, 4'h0, 8'h0, 1'b0, 32'h0, model_irq_next());
        do_reset();
        check("post_rst_irq", 32'(irq), 32'd0);
        read_all_mbox_zero();
        rd_cycle(18'h008, 32'h0, 1'b0);
        repeat (4) @(negedge clk);

        check("rsp_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
